// File: rtl/wb_queue.sv
// wb_queue: write-back buffer for the pipelined datapath.
// Producers hand in register write-back requests through a valid/ready
// handshake. The requests are held in order in a small circular FIFO and
// drained into the register file's single write port, one entry per cycle.
// Forwarding lookups on the two read addresses return the youngest queued
// value, so readers see writes that have not yet reached the register file.
// Optional feature macro: WBQ_BYPASS_EN. When it is defined, a request that
// arrives at an empty queue drives the write port in the same cycle and is
// never stored.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AW-1:0]           in_reg,
    input  logic signed [DW-1:0]    in_data,
    input  logic                    flush,
    output logic                    regWrite,
    output logic [AW-1:0]           writeR,
    output logic signed [DW-1:0]    writeD,
    input  logic [AW-1:0]           readR1,
    input  logic [AW-1:0]           readR2,
    output logic                    fwd1_hit,
    output logic signed [DW-1:0]    fwd1_data,
    output logic                    fwd2_hit,
    output logic signed [DW-1:0]    fwd2_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]        entry_reg  [DEPTH];
    logic signed [DW-1:0] entry_data [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;

    logic bypass;
    logic accept;
    logic push;
    logic pop;

`ifdef WBQ_BYPASS_EN
    assign bypass = (count == '0) && in_valid && (in_reg != '0);
`else
    assign bypass = 1'b0;
`endif

    // A full queue refuses new requests even while its head is draining.
    // Writes to register 0 are accepted but dropped, because r0 is hardwired.
    // The head is always popped, since the register file takes one write
    // every cycle.
    assign in_ready = (count != CW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_reg != '0) && !bypass;
    assign pop      = (count != '0);

    // Pointer and occupancy bookkeeping. Flush outranks both accept and pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // The entry storage needs no reset: count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            entry_reg[wr_ptr]  <= in_reg;
            entry_data[wr_ptr] <= in_data;
        end
    end

    // The write port presents the head entry, or the bypassed request when that feature is built in.
    always_comb begin
        regWrite = 1'b0;
        writeR   = '0;
        writeD   = '0;
        if (count != '0) begin
            regWrite = 1'b1;
            writeR   = entry_reg[rd_ptr];
            writeD   = entry_data[rd_ptr];
        end else if (bypass) begin
            regWrite = 1'b1;
            writeR   = in_reg;
            writeD   = in_data;
        end
    end

    // The scan runs from the oldest entry to the newest, so the last match is the youngest one.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] addr);
        logic          hit;
        logic [DW-1:0] data;
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (addr != '0) && (entry_reg[idx] == addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
        return {hit, data};
    endfunction

    // Forwarding lookup for read port 1.
    always_comb begin
        {fwd1_hit, fwd1_data} = lookup(readR1);
    end

    // Forwarding lookup for read port 2.
    always_comb begin
        {fwd2_hit, fwd2_data} = lookup(readR2);
    end

endmodule
